// File: rtl/mul_pkg.sv
// Shared op codes and result-select helper for the
// multiply issue controller.
package mul_pkg;

  localparam int MUL_OP_W = 2;

  localparam logic [MUL_OP_W-1:0] OP_MUL_W   = 2'b00;
  localparam logic [MUL_OP_W-1:0] OP_MULH_W  = 2'b01;
  localparam logic [MUL_OP_W-1:0] OP_MULH_WU = 2'b10;

  // High-word ops take P[63:32]; everything else, incl. 2'b11, the low word
  function automatic logic [31:0] mul_sel(
    input logic [MUL_OP_W-1:0] op,
    input logic [63:0]         p
  );
    logic [31:0] r;
    r = p[31:0];
    unique case (1'b1)
      (op == OP_MULH_W),
      (op == OP_MULH_WU): r = p[63:32];
      default:            r = p[31:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul_skid_buf.sv
// One-entry output buffer: parks a result while the
// consumer stalls, drains on ready, clears on flush.
module mul_skid_buf #(
  parameter int DW = 37
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          s_valid_i,
  input  logic [DW-1:0] s_data_i,
  input  logic          m_ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (s_valid_i && (valid_q ? m_ready_i : !m_ready_i)) begin
      valid_d = 1'b1;
      data_d  = s_data_i;
    end else if (valid_q && m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// EXE-side controller for the 1-cycle registered multiplier:
// operand drive, in-flight tracking, result select and skid.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_op,
  input  logic [31:0]         in_src1,
  input  logic [31:0]         in_src2,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                mul_sign,
  output logic [31:0]         mul_x,
  output logic [31:0]         mul_y,
  input  logic [63:0]         mul_p,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic [CNT_W-1:0]    retire_cnt
);

  localparam int DW = TAG_W + 32;

  logic                s1_valid_q, s1_valid_d;
  logic [MUL_OP_W-1:0] s1_op_q, s1_op_d;
  logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic          fire_in;
  logic          ob_valid;
  logic [DW-1:0] ob_data;
  logic [DW-1:0] s1_data;

  assign mul_x    = in_src1;
  assign mul_y    = in_src2;
  assign mul_sign = (in_op == OP_MULH_W);

  // Never accept while S1 would be stuck behind a full OB
  assign in_ready = !ob_valid && !(s1_valid_q && !out_ready);
  assign fire_in  = in_valid && in_ready && !flush;

  assign s1_data = {s1_tag_q, mul_sel(s1_op_q, mul_p)};

  always_comb begin
    s1_valid_d = fire_in;
    s1_op_d    = fire_in ? in_op  : s1_op_q;
    s1_tag_d   = fire_in ? in_tag : s1_tag_q;
    cnt_d      = cnt_q + ((out_valid && out_ready) ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_MUL_W;
      s1_tag_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      cnt_q      <= cnt_d;
    end
  end

  mul_skid_buf #(
    .DW(DW)
  ) u_ob (
    .clk      (clk),
    .rst_n    (resetn),
    .flush_i  (flush),
    .s_valid_i(s1_valid_q),
    .s_data_i (s1_data),
    .m_ready_i(out_ready),
    .valid_o  (ob_valid),
    .data_o   (ob_data)
  );

  assign out_valid = ob_valid || s1_valid_q;
  assign {out_tag, out_result} =
    ob_valid   ? ob_data :
    s1_valid_q ? s1_data : '0;
  assign retire_cnt = cnt_q;

endmodule
